// File: rtl/syscall_unit.sv
// rtl/syscall_unit.sv - syscall handler: print-hex, exit, pause-until-resume, event counter
module syscall_unit #(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] PRINT_CODE = 32'd34,
  parameter logic [31:0] EXIT_CODE  = 32'd10,
  parameter logic [31:0] PAUSE_CODE = 32'd50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             resume,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      disp,
  output logic             disp_valid,
  output logic [CNT_W-1:0] sys_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;

  // Only RUN accepts; in PAUSE the frozen PC may keep presenting the same syscall.
  assign accept = (state == RUN) && syscall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (accept) begin
          if (v0 == EXIT_CODE) begin
            state_next = HALT;
          end else if (v0 == PAUSE_CODE) begin
            state_next = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (resume) begin
          state_next = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Stall decodes registered state only, keeping syscall/v0 off the PC enable path.
  always_comb begin
    stall  = (state != RUN);
    halted = (state == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp       <= 32'd0;
      disp_valid <= 1'b0;
      sys_count  <= '0;
    end else if (accept) begin
      if (sys_count != {CNT_W{1'b1}}) begin
        sys_count <= sys_count + CNT_W'(1);
      end
      if (v0 == PRINT_CODE) begin
        disp       <= a0;
        disp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// tb/tb_syscall_unit.sv - directed self-checking bench for syscall_unit
module tb_syscall_unit;

  logic        clk;
  logic        rst;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        resume;

  logic        stall;
  logic        halted;
  logic [31:0] disp;
  logic        disp_valid;
  logic [15:0] sys_count;

  logic        stall_s;
  logic        halted_s;
  logic [31:0] disp_s;
  logic        disp_valid_s;
  logic [3:0]  count_s;

  int pass_cnt;
  int total_cnt;

  syscall_unit dut (
    .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0), .resume(resume),
    .stall(stall), .halted(halted), .disp(disp), .disp_valid(disp_valid),
    .sys_count(sys_count)
  );

  // Narrow counter instance sharing the same stimulus, used for saturation.
  syscall_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0), .resume(resume),
    .stall(stall_s), .halted(halted_s), .disp(disp_s), .disp_valid(disp_valid_s),
    .sys_count(count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    if (stall !== 1'b0) $display("FAIL reset_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL reset_halted got=%0h exp=0", halted); else pass_cnt++;
    total_cnt++;
    if (disp !== 32'd0) $display("FAIL reset_disp got=%0h exp=0", disp); else pass_cnt++;
    total_cnt++;
    if (disp_valid !== 1'b0) $display("FAIL reset_disp_valid got=%0h exp=0", disp_valid); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", sys_count); else pass_cnt++;
    total_cnt++;
    #9;
    rst = 1'b0;
  endtask

  task automatic test_print();
    syscall = 1'b1; v0 = 32'd34; a0 = 32'hDEADBEEF;
    step();
    syscall = 1'b0;
    if (disp !== 32'hDEADBEEF) $display("FAIL print_disp got=%0h exp=deadbeef", disp); else pass_cnt++;
    total_cnt++;
    if (disp_valid !== 1'b1) $display("FAIL print_valid got=%0h exp=1", disp_valid); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd1) $display("FAIL print_count got=%0d exp=1", sys_count); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL print_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_pause();
    syscall = 1'b1; v0 = 32'd50; a0 = 32'd0;
    step();
    if (stall !== 1'b1) $display("FAIL pause_stall got=%0h exp=1", stall); else pass_cnt++;
    total_cnt++;
    repeat (4) step();
    if (sys_count !== 16'd2) $display("FAIL pause_hold_count got=%0d exp=2", sys_count); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL pause_hold_stall got=%0h exp=1", stall); else pass_cnt++;
    total_cnt++;
    // Resume while a new syscall is already presented: ignored at the resume edge.
    resume = 1'b1; v0 = 32'd7;
    step();
    resume = 1'b0;
    if (stall !== 1'b0) $display("FAIL resume_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd2) $display("FAIL resume_edge_count got=%0d exp=2", sys_count); else pass_cnt++;
    total_cnt++;
    step();
    syscall = 1'b0;
    if (sys_count !== 16'd3) $display("FAIL first_run_count got=%0d exp=3", sys_count); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_early_resume();
    resume = 1'b1;
    step();
    resume = 1'b0;
    if (stall !== 1'b0) $display("FAIL early_resume_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
    syscall = 1'b1; v0 = 32'd50;
    step();
    syscall = 1'b0;
    repeat (3) step();
    if (stall !== 1'b1) $display("FAIL early_resume_kept_stall got=%0h exp=1", stall); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd4) $display("FAIL early_resume_count got=%0d exp=4", sys_count); else pass_cnt++;
    total_cnt++;
    resume = 1'b1;
    step();
    resume = 1'b0;
    if (stall !== 1'b0) $display("FAIL fresh_resume_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_other_code();
    // Low bits match PRINT_CODE, upper bits do not: must count only.
    syscall = 1'b1; v0 = 32'h0001_0022; a0 = 32'h55;
    step();
    syscall = 1'b0;
    if (disp !== 32'hDEADBEEF) $display("FAIL other_disp got=%0h exp=deadbeef", disp); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd5) $display("FAIL other_count got=%0d exp=5", sys_count); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL other_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_back_to_back();
    syscall = 1'b1; v0 = 32'd7; a0 = 32'h99;
    step();
    step();
    if (sys_count !== 16'd7) $display("FAIL b2b_count got=%0d exp=7", sys_count); else pass_cnt++;
    total_cnt++;
    if (count_s !== 4'd7) $display("FAIL b2b_count_small got=%0d exp=7", count_s); else pass_cnt++;
    total_cnt++;
    repeat (18) step();
    syscall = 1'b0;
    if (count_s !== 4'd15) $display("FAIL sat_count_small got=%0d exp=15", count_s); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd25) $display("FAIL sat_count_wide got=%0d exp=25", sys_count); else pass_cnt++;
    total_cnt++;
    if (stall_s !== 1'b0) $display("FAIL sat_stall got=%0h exp=0", stall_s); else pass_cnt++;
    total_cnt++;
    if (disp_s !== 32'hDEADBEEF) $display("FAIL sat_disp got=%0h exp=deadbeef", disp_s); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_exit();
    syscall = 1'b1; v0 = 32'd10;
    step();
    syscall = 1'b0;
    if (halted !== 1'b1) $display("FAIL exit_halted got=%0h exp=1", halted); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL exit_stall got=%0h exp=1", stall); else pass_cnt++;
    total_cnt++;
    resume = 1'b1;
    step();
    resume = 1'b0;
    syscall = 1'b1; v0 = 32'd34; a0 = 32'd5;
    step();
    step();
    syscall = 1'b0;
    if (halted !== 1'b1) $display("FAIL halt_absorb got=%0h exp=1", halted); else pass_cnt++;
    total_cnt++;
    if (disp !== 32'hDEADBEEF) $display("FAIL halt_disp got=%0h exp=deadbeef", disp); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd26) $display("FAIL halt_count got=%0d exp=26", sys_count); else pass_cnt++;
    total_cnt++;
    if (count_s !== 4'd15) $display("FAIL halt_count_small got=%0d exp=15", count_s); else pass_cnt++;
    total_cnt++;
    #2;
    rst = 1'b1;
    #1;
    if (halted !== 1'b0) $display("FAIL rst_halted got=%0h exp=0", halted); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd0) $display("FAIL rst_count got=%0d exp=0", sys_count); else pass_cnt++;
    total_cnt++;
    if (disp !== 32'd0) $display("FAIL rst_disp got=%0h exp=0", disp); else pass_cnt++;
    total_cnt++;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_async_reset_pause();
    syscall = 1'b1; v0 = 32'd50;
    step();
    syscall = 1'b0;
    if (stall !== 1'b1) $display("FAIL mid_pause_stall got=%0h exp=1", stall); else pass_cnt++;
    total_cnt++;
    #2;
    rst = 1'b1;
    #1;
    if (stall !== 1'b0) $display("FAIL async_rst_stall got=%0h exp=0", stall); else pass_cnt++;
    total_cnt++;
    #1;
    rst = 1'b0;
    syscall = 1'b1; v0 = 32'd34; a0 = 32'd1;
    step();
    syscall = 1'b0;
    if (disp !== 32'd1) $display("FAIL post_rst_disp got=%0h exp=1", disp); else pass_cnt++;
    total_cnt++;
    if (disp_valid !== 1'b1) $display("FAIL post_rst_valid got=%0h exp=1", disp_valid); else pass_cnt++;
    total_cnt++;
    if (sys_count !== 16'd1) $display("FAIL post_rst_count got=%0d exp=1", sys_count); else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst     = 1'b1;
    syscall = 1'b0;
    v0      = 32'd0;
    a0      = 32'd0;
    resume  = 1'b0;
    test_reset();
    test_print();
    test_pause();
    test_early_resume();
    test_other_code();
    test_back_to_back();
    test_exit();
    test_async_reset_pause();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Syscall handler that sits directly downstream of the register file.
- Consumes the regfile's dedicated v0/a0 taps whenever decode flags a SYSCALL instruction.
- Services three codes: print-hex (latch a0 to the board display), exit (halt the CPU), pause (freeze until a resume button pulse).
- Drives a stall line back to the PC/regfile write-enable logic and keeps a syscall event counter for the debug display.

Parameters:
- CNT_W, 16, width of the syscall event counter.
- PRINT_CODE, 34, v0 value selecting print-hex (disp <= a0).
- EXIT_CODE, 10, v0 value selecting halt.
- PAUSE_CODE, 50, v0 value selecting pause-until-resume.

Ports:
- clk  in  1  system clock; all state updates on posedge (regfile writes on negedge, so v0/a0 are settled).
- rst  in  1  asynchronous, active-high reset.
- syscall  in  1  decoded SYSCALL in the current instruction, level, valid for one cycle per instruction.
- v0  in  32  regfile register 2 contents (syscall code).
- a0  in  32  regfile register 4 contents (syscall argument).
- resume  in  1  single-cycle pulse, already debounced/synchronised externally.
- stall  out  1  freeze PC update and regfile write-enable.
- halted  out  1  CPU has executed exit.
- disp  out  32  last printed value.
- disp_valid  out  1  at least one print has occurred since reset.
- sys_count  out  CNT_W  number of syscalls accepted since reset.

Behaviour:
- Reset (async, rst=1, any time including mid-PAUSE/HALT):
  - state=RUN; stall=0, halted=0, disp=0, disp_valid=0, sys_count=0.
  - Deassertion is sampled by the next posedge.
- States: RUN, PAUSE, HALT, 2-bit registered.
  - stall = (state != RUN), decoded from registered state only; no combinational path from syscall/v0 to stall.
  - halted = (state == HALT).
- Acceptance: a syscall is accepted at a posedge when state==RUN and syscall==1. The syscall instruction itself completes normally (PC advances past it); stall takes effect from the following cycle, i.e. 1-cycle latency.
- On acceptance, sys_count increments, saturating at all-ones with no wrap. Action by v0 (full 32-bit compare):
  - PRINT_CODE: disp<=a0, disp_valid<=1, stay RUN.
  - EXIT_CODE: next state HALT.
  - PAUSE_CODE: next state PAUSE.
  - any other value: counted only, no other effect, stay RUN.
- PAUSE:
  - syscall input ignored, since PC is frozen and the same instruction may still be presented.
  - resume==1 at posedge -> RUN next cycle; stall drops in that cycle.
  - disp/disp_valid/sys_count held.
- HALT:
  - absorbing; only rst exits.
  - resume and syscall ignored; all outputs held.
- resume in RUN is ignored, with no latching of an early press.
- Back-to-back syscalls in RUN on consecutive cycles: each accepted and counted.
- After PAUSE->RUN, a syscall present in the first RUN cycle is a new instruction (PC has advanced) and is accepted.
- disp is updated only by PRINT_CODE; no other path writes it.

Test Plan:
- Reset then syscall=1, v0=34, a0=0xDEADBEEF for 1 cycle -> next cycle disp=0xDEADBEEF, disp_valid=1, sys_count=1, stall=0.
- syscall with v0=50 -> stall=1 from next cycle. Hold syscall=1 for 5 cycles -> sys_count unchanged (1 increment total). Pulse resume -> stall=0 the following cycle.
- syscall with v0=10 -> halted=1, stall=1. Then resume pulse and syscall v0=34, a0=5 -> no change (disp unchanged, count unchanged). Assert rst -> immediately halted=0, stall=0, sys_count=0, disp=0.
- resume pulse while in RUN, then syscall v0=50 -> enters PAUSE and stays stalled (early press not remembered) until a fresh resume.
- CNT_W=4: 20 consecutive syscalls with v0=7 -> sys_count saturates at 15; state stays RUN, disp untouched.
- rst asserted asynchronously mid-PAUSE, between clock edges -> stall drops before the next posedge; after release, syscall v0=34, a0=1 -> disp=1.
